ensemble_vote_combiner: RTL

ENSEMBLE_VOTE_COMBINER -- requirements
Module: ensemble_vote_combiner

---
 rtl/ensemble_vote_combiner.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/ensemble_vote_combiner.sv
// rtl/ensemble_vote_combiner.sv - 2-of-3 majority vote over three classifier result streams
// Optional vote statistics counters: define ENSEMBLE_VOTE_STATS_EN.
module ensemble_vote_combiner #(
  parameter int DATA_WIDTH   = 32,
  parameter int KEEP_WIDTH   = 4,
  parameter int LABEL_WIDTH  = 8,
  parameter int TIE_PRIORITY = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata_0,
  input  logic [KEEP_WIDTH-1:0] s_axis_tkeep_0,
  input  logic                  s_axis_tvalid_0,
  input  logic                  s_axis_tlast_0,
  output logic                  s_axis_tready_0,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata_1,
  input  logic [KEEP_WIDTH-1:0] s_axis_tkeep_1,
  input  logic                  s_axis_tvalid_1,
  input  logic                  s_axis_tlast_1,
  output logic                  s_axis_tready_1,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata_2,
  input  logic [KEEP_WIDTH-1:0] s_axis_tkeep_2,
  input  logic                  s_axis_tvalid_2,
  input  logic                  s_axis_tlast_2,
  output logic                  s_axis_tready_2,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic                  tlast_mismatch
`ifdef ENSEMBLE_VOTE_STATS_EN
  ,
  output logic [31:0]           stat_unanimous,
  output logic [31:0]           stat_tie
`endif
);

  typedef enum logic {COLLECT = 1'b0, EMIT = 1'b1} state_t;

  localparam logic [1:0] TIE_IDX = 2'(TIE_PRIORITY);

  state_t                      state_q, state_d;
  logic [2:0][LABEL_WIDTH-1:0] lbl_q, lbl_d;
  logic [2:0]                  last_q, last_d;
  logic [2:0]                  full_q, full_d;
  logic [2:0]                  rdy_q, rdy_d;
  logic [DATA_WIDTH-1:0]       out_data_q, out_data_d;
  logic                        out_last_q, out_last_d;
  logic                        mism_q, mism_d;

  logic [2:0][LABEL_WIDTH-1:0] in_lbl;
  logic [2:0]                  in_last;
  logic [2:0]                  in_valid;
  logic                        hs_out;
  logic [LABEL_WIDTH-1:0]      vote_lbl;
  logic [1:0]                  vote_cnt;
  logic [DATA_WIDTH-1:0]       vote_data;
  logic                        unused_inputs;

  assign in_lbl   = {s_axis_tdata_2[LABEL_WIDTH-1:0], s_axis_tdata_1[LABEL_WIDTH-1:0],
                     s_axis_tdata_0[LABEL_WIDTH-1:0]};
  assign in_last  = {s_axis_tlast_2, s_axis_tlast_1, s_axis_tlast_0};
  assign in_valid = {s_axis_tvalid_2, s_axis_tvalid_1, s_axis_tvalid_0};

  // Keep and the non-label payload carry nothing the vote needs.
  assign unused_inputs = ^{s_axis_tkeep_0, s_axis_tkeep_1, s_axis_tkeep_2,
                           s_axis_tdata_0[DATA_WIDTH-1:LABEL_WIDTH],
                           s_axis_tdata_1[DATA_WIDTH-1:LABEL_WIDTH],
                           s_axis_tdata_2[DATA_WIDTH-1:LABEL_WIDTH]};

  assign s_axis_tready_0 = rdy_q[0];
  assign s_axis_tready_1 = rdy_q[1];
  assign s_axis_tready_2 = rdy_q[2];
  assign m_axis_tvalid   = (state_q == EMIT);
  assign m_axis_tkeep    = {KEEP_WIDTH{m_axis_tvalid}};
  assign m_axis_tdata    = out_data_q;
  assign m_axis_tlast    = out_last_q;
  assign tlast_mismatch  = mism_q;
  assign hs_out          = m_axis_tvalid & m_axis_tready;

  always_comb begin
    vote_lbl = lbl_q[TIE_IDX];
    vote_cnt = 2'd1;
    if ((lbl_q[0] == lbl_q[1]) && (lbl_q[1] == lbl_q[2])) begin
      vote_lbl = lbl_q[0];
      vote_cnt = 2'd3;
    end else if ((lbl_q[0] == lbl_q[1]) || (lbl_q[0] == lbl_q[2])) begin
      vote_lbl = lbl_q[0];
      vote_cnt = 2'd2;
    end else if (lbl_q[1] == lbl_q[2]) begin
      vote_lbl = lbl_q[1];
      vote_cnt = 2'd2;
    end
    vote_data = '0;
    vote_data[LABEL_WIDTH-1:0]            = vote_lbl;
    vote_data[DATA_WIDTH-1:DATA_WIDTH-2]  = vote_cnt;
  end

  always_comb begin
    state_d    = state_q;
    lbl_d      = lbl_q;
    last_d     = last_q;
    full_d     = full_q;
    out_data_d = out_data_q;
    out_last_d = out_last_q;
    mism_d     = mism_q;

    for (int k = 0; k < 3; k++) begin
      if (in_valid[k] && rdy_q[k]) begin
        lbl_d[k]  = in_lbl[k];
        last_d[k] = in_last[k];
        full_d[k] = 1'b1;
      end
    end

    case (state_q)
      COLLECT: begin
        if (&full_q) begin
          state_d    = EMIT;
          out_data_d = vote_data;
          out_last_d = |last_q;
          mism_d     = mism_q | ~((&last_q) | ~(|last_q));
        end
      end
      EMIT: begin
        if (m_axis_tready) state_d = COLLECT;
      end
      default: state_d = COLLECT;
    endcase

    if (hs_out) full_d = '0;
    // Ready is registered from the next-cycle occupancy so it never lags a capture.
    rdy_d = ~full_d;
  end

`ifdef ENSEMBLE_VOTE_STATS_EN
  logic [31:0] stat_u_q, stat_u_d;
  logic [31:0] stat_t_q, stat_t_d;

  assign stat_unanimous = stat_u_q;
  assign stat_tie       = stat_t_q;

  always_comb begin
    stat_u_d = stat_u_q;
    stat_t_d = stat_t_q;
    if (hs_out && (out_data_q[DATA_WIDTH-1:DATA_WIDTH-2] == 2'd3)) stat_u_d = stat_u_q + 32'd1;
    if (hs_out && (out_data_q[DATA_WIDTH-1:DATA_WIDTH-2] == 2'd1)) stat_t_d = stat_t_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_u_q <= '0;
      stat_t_q <= '0;
    end else begin
      stat_u_q <= stat_u_d;
      stat_t_q <= stat_t_d;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= COLLECT;
      lbl_q      <= '0;
      last_q     <= '0;
      full_q     <= '0;
      rdy_q      <= '0;
      out_data_q <= '0;
      out_last_q <= 1'b0;
      mism_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      lbl_q      <= lbl_d;
      last_q     <= last_d;
      full_q     <= full_d;
      rdy_q      <= rdy_d;
      out_data_q <= out_data_d;
      out_last_q <= out_last_d;
      mism_q     <= mism_d;
    end
  end

endmodule
